shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 15 +
 rtl/shift_sequencer_barrel_shifter.sv | 25 ++
 rtl/shift_sequencer.sv | 102 ++++++++++
 tb/tb_shift_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One pass of the barrel shifter moves at most STEP_MAX bits,
    // so STEP_MAX must fit in SEL_W bits.
    localparam int STEP_MAX = 7;
    localparam int SEL_W    = 3;

endpackage

// File: rtl/shift_sequencer_barrel_shifter.sv
// Single-cycle logical barrel shifter: log-stage mux chain, zero fill, 0..7 bit range.
module Barrel_Shifter
    import shift_sequencer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [SEL_W-1:0] sh,
    input  logic             RL_Sel,
    input  logic [N-1:0]     RN_In,
    output logic [N-1:0]     Shift_Out
);

    logic [N-1:0] stage [0:SEL_W];

    assign stage[0] = RN_In;

    // Stage i shifts by 2**i when sh[i] is set; RL_Sel = 1 selects right.
    for (genvar i = 0; i < SEL_W; i++) begin : g_stage
        assign stage[i+1] = !sh[i] ? stage[i]
                          : (RL_Sel ? (stage[i] >> (1 << i)) : (stage[i] << (1 << i)));
    end

    assign Shift_Out = stage[SEL_W];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass logical shifter: applies up to STEP_MAX bits per cycle until the
// requested amount is consumed, then holds the result under valid/ready.
module shift_sequencer #(
    parameter int N        = 32,
    parameter int AMT_W    = 5,
    parameter int STEP_MAX = shift_sequencer_pkg::STEP_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic             dir,
    input  logic [AMT_W-1:0] amt,
    input  logic [N-1:0]     data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     data_out,
    output logic             busy
);

    import shift_sequencer_pkg::*;

    localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     acc;
    logic [N-1:0]     shifted;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] step;
    logic             dir_q;
    logic             accept;

    assign accept = start && in_ready;

    // Per-pass amount: whatever is left, capped at what one pass can do.
    assign step = (rem > STEP_LIM) ? STEP_LIM : rem;

    Barrel_Shifter #(
        .N(N)
    ) u_shifter (
        .sh       (step[SEL_W-1:0]),
        .RL_Sel   (dir_q),
        .RN_In    (acc),
        .Shift_Out(shifted)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous and aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (amt != '0) ? SHIFT : DONE;
            SHIFT:   if (rem <= STEP_LIM) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            rem   <= '0;
            dir_q <= 1'b0;
        end else if (accept) begin
            acc   <= data_in;
            rem   <= amt;
            dir_q <= dir;
        end else if (state == SHIFT) begin
            acc   <= shifted;
            rem   <= rem - step;
        end
    end

    // acc only changes on accept or in SHIFT, so the result is stable in DONE.
    assign data_out = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer using an expected-result scoreboard.
module tb_shift_sequencer;

    localparam int N     = 32;
    localparam int AMT_W = 5;

    typedef struct {
        logic [N-1:0] data;
        int           lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in_ready;
    logic             dir;
    logic [AMT_W-1:0] amt;
    logic [N-1:0]     data_in;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     data_out;
    logic             busy;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t sb[$];

    shift_sequencer #(
        .N    (N),
        .AMT_W(AMT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_ready (in_ready),
        .dir      (dir),
        .amt      (amt),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference result and latency computed directly from the request.
    function automatic exp_t model(input logic [N-1:0] d, input logic [AMT_W-1:0] a, input logic dr);
        exp_t e;
        e.data = dr ? (d >> a) : (d << a);
        e.lat  = (int'(a) + 6) / 7 + 1;
        return e;
    endfunction

    // Issue one request, wait for the result, hold it for `hold` cycles, then drain.
    task automatic do_req(input logic [N-1:0] d, input logic [AMT_W-1:0] a, input logic dr,
                          input int hold, input bit scramble);
        int           cyc;
        exp_t         e;
        logic [N-1:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("idle_before_req", in_ready, 1);
        data_in = d;
        amt     = a;
        dir     = dr;
        start   = 1'b1;
        sb.push_back(model(d, a, dr));
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!out_valid && cyc < 64) begin
            if (scramble) begin
                data_in   = $urandom;
                amt       = AMT_W'($urandom);
                dir       = 1'($urandom);
                start     = 1'($urandom);
                out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        e = sb.pop_front();
        check("latency", cyc, e.lat);
        check("data_out", data_out, e.data);
        check("busy_in_done", busy, 1);
        check("in_ready_in_done", in_ready, 0);
        held = data_out;
        for (int i = 0; i < hold; i++) begin
            start = i[0];
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_data", data_out, held);
            check("hold_in_ready", in_ready, 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_in_ready", in_ready, 1);
        check("drain_valid", out_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        dir       = 1'b0;
        amt       = '0;
        data_in   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        @(negedge clk);
        reset = 1'b0;

        do_req(32'h8000_0001, 5'd0, 1'b0, 0, 1'b0);
        do_req(32'hFFFF_FFFF, 5'd31, 1'b1, 0, 1'b0);
        do_req(32'h0000_0001, 5'd7, 1'b0, 0, 1'b0);
        do_req(32'h0000_0001, 5'd8, 1'b0, 0, 1'b0);
        do_req(32'hDEAD_BEEF, 5'd14, 1'b1, 5, 1'b0);
        do_req(32'hA5A5_5A5A, 5'd15, 1'b0, 0, 1'b0);

        // Abort an amt = 31 request during its third SHIFT cycle.
        data_in = 32'hFFFF_FFFF;
        amt     = 5'd31;
        dir     = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_busy_shift", busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_still_shift", busy && !out_valid, 1);
        #1 reset = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_data_out", data_out, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        do_req(32'h1234_5678, 5'd9, 1'b0, 0, 1'b0);

        do_req(32'hCAFE_F00D, 5'd20, 1'b1, 2, 1'b1);
        do_req(32'h0F0F_0F0F, 5'd0, 1'b0, 0, 1'b1);

        for (int k = 0; k < 10; k++) begin
            do_req($urandom, AMT_W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
